// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle for serial_subtractor: operands and start in, status and result out.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Define SERIAL_SUB_OVERFLOW_EN to build the signed-overflow flag; otherwise overflow is tied to 0.
//
// state | meaning
// IDLE  | waiting for start, ready=1, result held
// SHIFT | one bit per cycle for WIDTH cycles, busy=1, start ignored
// DONE  | one-cycle done pulse, ready=1, start accepted back-to-back
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             borrow_q;

  logic accept;
  logic last;
  logic d_bit;
  logic br_next;

  assign accept  = ready_q & bus.start;
  assign last    = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign d_bit   = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            br      <= 1'b0;
            cnt     <= '0;
            state   <= SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          // The final bit goes straight into diff so the result lands on the completion edge.
          if (last) begin
            state    <= DONE;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            diff_q   <= {d_bit, res_sr[WIDTH-1:1]};
            borrow_q <= br_next;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic sign_a;
  logic sign_b;
  logic ovf_q;

  // The final d_bit is the result MSB, compared against the captured operand signs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        sign_a <= bus.a[WIDTH-1];
        sign_b <= bus.b[WIDTH-1];
      end
      if (last) begin
        ovf_q <= (sign_a != sign_b) && (d_bit != sign_a);
      end
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): vector table, handshake corner cases, strided sweep.
module tb_serial_subtractor;

  localparam int W = 8;
`ifdef SERIAL_SUB_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_subtractor_if #(.WIDTH(W)) sif ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_ovf(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] dd;
    dd = x - y;
    return OVF_ON && (x[7] != y[7]) && (dd[7] != x[7]);
  endfunction

  // Launch one operation from IDLE or DONE and check latency, busy length, result and hold.
  task automatic run_vec(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [7:0] ed, input logic ebr, input logic eov);
    logic [7:0] prev_d;
    logic       prev_b;
    logic       prev_o;
    int         lat;
    int         busy_n;
    logic       stable;
    prev_d = sif.diff;
    prev_b = sif.borrow_out;
    prev_o = sif.overflow;
    sif.start = 1'b1;
    sif.a = ta;
    sif.b = tb_v;
    tick();
    sif.start = 1'b0;
    sif.a = 8'($urandom);
    sif.b = 8'($urandom);
    lat = 0;
    busy_n = 0;
    stable = 1'b1;
    while (!sif.done && lat < 40) begin
      if (sif.busy) busy_n++;
      if (sif.diff !== prev_d || sif.borrow_out !== prev_b || sif.overflow !== prev_o) stable = 1'b0;
      tick();
      lat++;
    end
    check($sformatf("%s_latency a=%0h b=%0h", tag, ta, tb_v), lat, 8);
    check($sformatf("%s_busy_cycles a=%0h b=%0h", tag, ta, tb_v), busy_n, 8);
    check($sformatf("%s_hold_in_shift a=%0h b=%0h", tag, ta, tb_v), {31'd0, stable}, 1);
    check($sformatf("%s_result{diff,br,ov} a=%0h b=%0h", tag, ta, tb_v),
          {22'd0, sif.diff, sif.borrow_out, sif.overflow}, {22'd0, ed, ebr, eov});
  endtask

  initial begin
    logic [7:0] ba[3];
    logic [7:0] bb[3];
    logic [7:0] bd[3];
    int         t;
    int         last_t;
    int         ndone;
    int         extra;
    logic       prev_done;
    logic       idle_seen;
    logic [7:0] x;
    logic [7:0] y;

    checks = 0;
    failures = 0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    vecs[8] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
    vecs[9] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    sif.start = 1'b0;
    sif.a = 8'h00;
    sif.b = 8'h00;
    #17;
    rst_n = 1'b1;
    tick();
    check("reset_ready", {31'd0, sif.ready}, 1);
    check("reset_busy", {31'd0, sif.busy}, 0);
    check("reset_done", {31'd0, sif.done}, 0);
    check("reset_diff", {24'd0, sif.diff}, 0);
    check("reset_borrow", {31'd0, sif.borrow_out}, 0);
    check("reset_overflow", {31'd0, sif.overflow}, 0);

    for (int i = 0; i < 10; i++)
      run_vec("vec", vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ov & OVF_ON);
    tick();
    check("after_done_idle_ready", {31'd0, sif.ready}, 1);
    check("after_done_no_done", {31'd0, sif.done}, 0);

    // Back-to-back with start held high; new operands presented in each DONE cycle.
    ba = '{8'h20, 8'h10, 8'h55};
    bb = '{8'h10, 8'h20, 8'hAA};
    bd = '{8'h10, 8'hF0, 8'hAB};
    sif.start = 1'b1;
    sif.a = ba[0];
    sif.b = bb[0];
    tick();
    t = 0;
    last_t = -1;
    ndone = 0;
    prev_done = 1'b0;
    idle_seen = 1'b0;
    while (ndone < 3 && t < 60) begin
      if (sif.ready && !sif.done) idle_seen = 1'b1;
      if (sif.done) begin
        check("b2b_done_width", {31'd0, prev_done}, 0);
        if (last_t >= 0) check("b2b_period", t - last_t, 9);
        check("b2b_diff", {24'd0, sif.diff}, {24'd0, bd[ndone]});
        last_t = t;
        ndone++;
        if (ndone < 3) begin
          sif.a = ba[ndone];
          sif.b = bb[ndone];
        end else begin
          sif.start = 1'b0;
        end
      end
      prev_done = sif.done;
      tick();
      t++;
    end
    check("b2b_results", ndone, 3);
    check("b2b_no_idle", {31'd0, idle_seen}, 0);
    check("b2b_done_single", {31'd0, sif.done}, 0);

    // Second start during SHIFT must be ignored and not queued.
    tick();
    sif.start = 1'b1;
    sif.a = 8'h05;
    sif.b = 8'h03;
    tick();
    sif.start = 1'b0;
    t = 0;
    repeat (3) begin
      tick();
      t++;
    end
    sif.start = 1'b1;
    sif.a = 8'h11;
    sif.b = 8'h22;
    tick();
    t++;
    sif.start = 1'b0;
    while (!sif.done && t < 40) begin
      tick();
      t++;
    end
    check("ign_latency", t, 8);
    check("ign_diff", {24'd0, sif.diff}, 32'h02);
    check("ign_borrow", {31'd0, sif.borrow_out}, 0);
    extra = 0;
    repeat (12) begin
      tick();
      if (sif.done || sif.busy) extra++;
    end
    check("ign_not_queued", extra, 0);

    // Asynchronous reset in the 4th SHIFT cycle aborts the operation.
    sif.start = 1'b1;
    sif.a = 8'h10;
    sif.b = 8'h01;
    tick();
    sif.start = 1'b0;
    repeat (3) tick();
    check("rst_pre_busy", {31'd0, sif.busy}, 1);
    rst_n = 1'b0;
    #2;
    check("rst_busy", {31'd0, sif.busy}, 0);
    check("rst_ready", {31'd0, sif.ready}, 1);
    check("rst_done", {31'd0, sif.done}, 0);
    check("rst_diff", {24'd0, sif.diff}, 0);
    check("rst_borrow", {31'd0, sif.borrow_out}, 0);
    #10;
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      tick();
      if (sif.done) extra++;
    end
    check("rst_no_done", extra, 0);
    run_vec("post_rst", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    // Strided sweep: 32 values per operand covering 0x00, 0x7F, 0x80, 0xFF.
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        x = 8'((i * 8) | (i & 7));
        y = 8'((j * 8) | (j & 7));
        run_vec("sweep", x, y, x - y, (x < y), exp_ovf(x, y));
      end
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
